sram_ctrl: RTL and testbench

- Memory-side stage between the cpu core's word-oriented request port and one external 256Kx16 asynchronous SRAM (IS61LV25616 class).
- Accepts 32-bit word read/write requests and splits each into two 16-bit halfword SRAM cycles, low half first.
- Generates CE_/OE_/WE_/LB_/UB_ timing with programmable wait states and returns a one-cycle ready pulse.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding, half-select
// constants, the default wait-state count and a byte-enable helper.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRd      = 3'd1,
        StWrSetup = 3'd2,
        StWrPulse = 3'd3,
        StWrHold  = 3'd4,
        StDone    = 3'd5
    } state_e;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 1;

    // Byte-enable pair {ub, lb} belonging to the selected 16-bit half.
    function automatic logic [1:0] half_be(input logic [3:0] be, input logic half);
        return half ? be[3:2] : be[1:0];
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: turns 32-bit word read/write requests into two 16-bit cycles on an
// external asynchronous SRAM (256Kx16 class), low half first, with programmable
// wait states. All outputs are registered.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req, we, addr,      request strobe (sampled in IDLE), direction, word address,
//   wdata, be           write data and byte enables, captured with req
//   rdata               read data, updated only at read sample points
//   ready, busy         one-cycle completion pulse, transaction-in-flight flag
//   sram_addr           halfword address {word_addr, half}
//   sram_dq_i/_o/_oe    SRAM data in, data out and its tri-state enable
//   sram_*_n            active-low CE/OE/WE/LB/UB
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [29:0]           addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            be,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [15:0]           sram_dq_i,
    output logic [15:0]           sram_dq_o,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_lb_n,
    output logic                  sram_ub_n
);

    localparam int unsigned WordW    = ADDR_WIDTH - 1;
    localparam logic [3:0]  WaitLast = 4'(WAIT_CYCLES);

    state_e           r_state, w_state_d;
    logic             r_half, w_half_d;
    logic [3:0]       r_wait, w_wait_d;
    logic [WordW-1:0] r_word, w_word_d;
    logic [31:0]      r_wdata, w_wdata_d;
    logic [3:0]       r_be, w_be_d;

    logic [ADDR_WIDTH-1:0] w_addr_d;
    logic [15:0]           w_dq_o_d;
    logic                  w_dq_oe_d, w_ce_n_d, w_oe_n_d, w_we_n_d, w_lb_n_d, w_ub_n_d;
    logic                  w_ready_d, w_busy_d;
    logic                  w_sample;

    // Word address bits above the SRAM range are ignored (address wraps).
    logic w_unused_addr;
    assign w_unused_addr = ^addr[29:WordW];

    // Read data is captured at the end of the last strobe cycle of each half.
    assign w_sample = (r_state == StRd) && (r_wait == WaitLast);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_half  <= HALF_LO;
            r_wait  <= '0;
            r_word  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_d;
            r_half  <= w_half_d;
            r_wait  <= w_wait_d;
            r_word  <= w_word_d;
            r_wdata <= w_wdata_d;
            r_be    <= w_be_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_d = r_state;
        w_half_d  = r_half;
        w_wait_d  = r_wait;
        w_word_d  = r_word;
        w_wdata_d = r_wdata;
        w_be_d    = r_be;
        unique case (r_state)
            StIdle: begin
                if (req) begin
                    w_word_d  = addr[WordW-1:0];
                    w_wdata_d = wdata;
                    w_be_d    = be;
                    w_wait_d  = '0;
                    w_half_d  = HALF_LO;
                    if (!we) begin
                        w_state_d = StRd;
                    end else if (|be[1:0]) begin
                        w_state_d = StWrSetup;
                    end else if (|be[3:2]) begin
                        w_state_d = StWrSetup;
                        w_half_d  = HALF_HI;
                    end else begin
                        w_state_d = StDone;
                    end
                end
            end
            StRd: begin
                if (r_wait == WaitLast) begin
                    w_wait_d = '0;
                    if (r_half == HALF_LO) begin
                        w_half_d = HALF_HI;
                    end else begin
                        w_state_d = StDone;
                    end
                end else begin
                    w_wait_d = r_wait + 4'd1;
                end
            end
            StWrSetup: begin
                w_state_d = StWrPulse;
                w_wait_d  = '0;
            end
            StWrPulse: begin
                if (r_wait == WaitLast) begin
                    w_state_d = StWrHold;
                end else begin
                    w_wait_d = r_wait + 4'd1;
                end
            end
            StWrHold: begin
                // A high half with no enabled bytes is skipped entirely.
                if ((r_half == HALF_LO) && (|r_be[3:2])) begin
                    w_state_d = StWrSetup;
                    w_half_d  = HALF_HI;
                end else begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Decoded from the next state so the registered pins line up with the state.
    always_comb begin
        w_addr_d  = sram_addr;
        w_dq_o_d  = sram_dq_o;
        w_dq_oe_d = 1'b0;
        w_ce_n_d  = 1'b1;
        w_oe_n_d  = 1'b1;
        w_we_n_d  = 1'b1;
        w_lb_n_d  = 1'b1;
        w_ub_n_d  = 1'b1;
        w_ready_d = (w_state_d == StDone);
        w_busy_d  = (w_state_d != StIdle);
        unique case (w_state_d)
            StRd: begin
                w_addr_d = {w_word_d, w_half_d};
                w_ce_n_d = 1'b0;
                w_oe_n_d = 1'b0;
                w_lb_n_d = 1'b0;
                w_ub_n_d = 1'b0;
            end
            StWrSetup, StWrPulse, StWrHold: begin
                w_addr_d               = {w_word_d, w_half_d};
                w_dq_o_d               = w_half_d ? w_wdata_d[31:16] : w_wdata_d[15:0];
                w_dq_oe_d              = 1'b1;
                w_ce_n_d               = 1'b0;
                w_we_n_d               = (w_state_d != StWrPulse);
                {w_ub_n_d, w_lb_n_d}   = ~half_be(w_be_d, w_half_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata      <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
        end else begin
            if (w_sample) begin
                if (r_half == HALF_HI) begin
                    rdata[31:16] <= sram_dq_i;
                end else begin
                    rdata[15:0] <= sram_dq_i;
                end
            end
            ready      <= w_ready_d;
            busy       <= w_busy_d;
            sram_addr  <= w_addr_d;
            sram_dq_o  <= w_dq_o_d;
            sram_dq_oe <= w_dq_oe_d;
            sram_ce_n  <= w_ce_n_d;
            sram_oe_n  <= w_oe_n_d;
            sram_we_n  <= w_we_n_d;
            sram_lb_n  <= w_lb_n_d;
            sram_ub_n  <= w_ub_n_d;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural 256Kx16 SRAM model.
module tb_sram_ctrl;

    localparam int W = 1;

    typedef struct {
        logic        is_rd;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ready, busy;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_i = 16'h0;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    exp_t        sb_q[$];
    logic [15:0] mem[int unsigned];
    logic [15:0] wr_v;
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, acc_cyc = 0, we_total = 0, we_run = 0, oe_run = 0;
    logic        busy_prev = 1'b0;
    logic [2:0]  prev_wr = 3'b011;  // {dq_oe, ce_n, we_n} of the previous cycle

    sram_ctrl #(.ADDR_WIDTH(18), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .be         (be),
        .rdata      (rdata),
        .ready      (ready),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_lb_n  (sram_lb_n),
        .sram_ub_n  (sram_ub_n)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memrd(input int unsigned a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
    endfunction

    // SRAM model: byte-lane writes while CE and WE are low, async read latched mid-cycle.
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            wr_v = memrd(32'(sram_addr));
            if (!sram_lb_n) wr_v[7:0] = sram_dq_o[7:0];
            if (!sram_ub_n) wr_v[15:8] = sram_dq_o[15:8];
            mem[32'(sram_addr)] = wr_v;
        end
    end

    always @(negedge clk) begin
        sram_dq_i <= (!sram_ce_n && !sram_oe_n) ? memrd(32'(sram_addr)) : 16'h0000;
    end

    always @(posedge clk) cyc++;

    // Monitor: protocol checks every cycle and scoreboard pop on each ready pulse.
    always @(negedge clk) begin
        if (rst) begin
            busy_prev = 1'b0;
            we_run    = 0;
            oe_run    = 0;
            prev_wr   = 3'b011;
        end else begin
            if (busy && !busy_prev) acc_cyc = cyc;
            busy_prev = busy;
            chk("dq_oe_with_oe_n", {31'b0, sram_dq_oe & ~sram_oe_n}, 32'd0);
            if (!sram_we_n) begin
                if (we_run == 0) chk("we_setup", {29'b0, prev_wr}, 32'b101);
                we_run++;
                we_total++;
            end else if (we_run > 0) begin
                chk("we_pulse_width", 32'(we_run), 32'(W + 1));
                chk("we_hold_dq_oe", {31'b0, sram_dq_oe}, 32'd1);
                we_run = 0;
            end
            if (!sram_oe_n) begin
                oe_run++;
            end else if (oe_run > 0) begin
                chk("oe_read_width", 32'(oe_run), 32'(2 * (W + 1)));
                oe_run = 0;
            end
            if (ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
                    if (e.is_rd) chk("rdata", rdata, e.rd);
                end
            end
            prev_wr = {sram_dq_oe, sram_ce_n, sram_we_n};
        end
    end

    task automatic wait_ready(output int rc);
        rc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic iwe, input logic [29:0] ia, input logic [31:0] iwd,
                         input logic [3:0] ibe, input logic [31:0] exp_rd, input int exp_lat);
        int rc;
        exp_t e;
        @(negedge clk);
        we = iwe; addr = ia; wdata = iwd; be = ibe; req = 1'b1;
        e.is_rd = ~iwe; e.rd = exp_rd; e.lat = exp_lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1 req = 1'b0;
        wait_ready(rc);
    endtask

    initial begin
        int rc;
        int we_before;
        exp_t e;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: controls inactive, no activity.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_ctrl", {24'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
                               sram_dq_oe, ready, busy}, 32'h0000_00F8);
            chk("reset_data", rdata | {14'b0, sram_addr}, 32'd0);
        end

        // Full write, then read back.
        issue(1'b1, 30'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 2 * (W + 3) + 1);
        chk("mem_20", {16'b0, memrd(32'h20)}, 32'hBEEF);
        chk("mem_21", {16'b0, memrd(32'h21)}, 32'hDEAD);
        issue(1'b0, 30'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 2 * (W + 1) + 1);

        // High-half-only write: low half is never touched.
        issue(1'b1, 30'h10, 32'h1234_5678, 4'hC, 32'h0, (W + 3) + 1);
        chk("mem_21_hi", {16'b0, memrd(32'h21)}, 32'h1234);
        chk("mem_20_kept", {16'b0, memrd(32'h20)}, 32'hBEEF);
        issue(1'b0, 30'h10, 32'h0, 4'h0, 32'h1234_BEEF, 2 * (W + 1) + 1);

        // Low-half and single-byte writes.
        issue(1'b1, 30'h10, 32'h0000_CAFE, 4'h3, 32'h0, (W + 3) + 1);
        chk("mem_20_lo", {16'b0, memrd(32'h20)}, 32'hCAFE);
        issue(1'b1, 30'h10, 32'h0000_00AA, 4'h1, 32'h0, (W + 3) + 1);
        chk("mem_20_byte", {16'b0, memrd(32'h20)}, 32'hCAAA);
        chk("mem_21_byte", {16'b0, memrd(32'h21)}, 32'h1234);

        // be=0 write with req held high into a back-to-back read.
        @(negedge clk);
        we_before = we_total;
        we = 1'b1; addr = 30'h10; wdata = '0; be = 4'h0; req = 1'b1;
        e.is_rd = 1'b0; e.rd = '0; e.lat = 1;
        sb_q.push_back(e);
        e.is_rd = 1'b1; e.rd = 32'h1234_CAAA; e.lat = 2 * (W + 1) + 1;
        sb_q.push_back(e);
        @(posedge clk);
        #1 we = 1'b0;
        wait_ready(rc);
        begin
            int bc;
            bc = -1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (busy) begin
                    bc = cyc;
                    break;
                end
            end
            chk("b2b_accept_gap", 32'(bc - rc), 32'd2);
        end
        req = 1'b0;
        wait_ready(rc);
        chk("be0_no_we", 32'(we_total - we_before), 32'd0);

        // Address wrap: only the low 17 word-address bits reach the SRAM.
        issue(1'b1, 30'h1555_FFFF, 32'h0F0F_1E1E, 4'hF, 32'h0, 2 * (W + 3) + 1);
        chk("wrap_3fffe", {16'b0, memrd(32'h3FFFE)}, 32'h1E1E);
        chk("wrap_3ffff", {16'b0, memrd(32'h3FFFF)}, 32'h0F0F);
        chk("wrap_no_carry", {16'b0, memrd(32'h0)}, 32'h0);
        issue(1'b0, 30'h0001_FFFF, 32'h0, 4'h0, 32'h0F0F_1E1E, 2 * (W + 1) + 1);

        // Reset in the middle of the first write pulse.
        @(negedge clk);
        we = 1'b1; addr = 30'h30; wdata = 32'hAAAA_5555; be = 4'hF; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        rc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sram_we_n) begin
                rc = cyc;
                break;
            end
        end
        chk("rst_reached_pulse", {31'b0, sram_we_n}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ctrl", {28'b0, sram_we_n, sram_ce_n, sram_dq_oe, busy}, 32'b1100);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_ready", {31'b0, ready}, 32'd0);
        issue(1'b0, 30'h30, 32'h0, 4'h0, 32'h0000_0000, 2 * (W + 1) + 1);

        // Drain.
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
